// File: rtl/tteframe_ingress_sink.sv
// Ingress sink: parses the 2-byte switch header, stores frame bodies
// in a circular byte buffer, and pushes descriptors to the egress queues.
// Ports:
//   clk, rstn       clock, async active-low reset
//   sof, dv, data   frame stream in
//   bp              registered backpressure to the source
//   dbuf_we/addr/din  registered byte-buffer write port
//   buf_rd_ptr      oldest unreleased byte, from egress
//   commit_ptr      first byte after the last committed frame
//   desc_wr/din     per-port descriptor push {start_addr, body_len}
//   desc_full       per-port descriptor FIFO full
//   frame_cnt, drop_cnt  saturating statistics
module tteframe_ingress_sink #(
  parameter int ADDR_W   = 12,
  parameter int MAX_FRM  = 1536,
  parameter int MAX_BODY = 2047
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sof,
  input  logic              dv,
  input  logic [7:0]        data,
  output logic              bp,
  output logic              dbuf_we,
  output logic [ADDR_W-1:0] dbuf_addr,
  output logic [7:0]        dbuf_din,
  input  logic [ADDR_W-1:0] buf_rd_ptr,
  output logic [ADDR_W-1:0] commit_ptr,
  output logic [3:0]        desc_wr,
  output logic [ADDR_W+10:0] desc_din,
  input  logic [3:0]        desc_full,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int LEN_W = 11;
  localparam logic [LEN_W-1:0] BODY_LIM = LEN_W'(MAX_BODY);
  localparam logic [ADDR_W:0] FRM_LIM = (ADDR_W+1)'(MAX_FRM);

  typedef enum logic [2:0] {
    IDLE,
    HDR1,
    BODY,
    DISCARD,
    COMMIT
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
  logic [ADDR_W-1:0] commit_n;
  logic [ADDR_W-1:0] start_addr, start_n;
  logic [LEN_W-1:0]  body_len, len_n;
  logic [3:0]        portmap, pm_n;
  logic              we_n;
  logic [2:0]        drop_inc;
  logic              frame_inc;
  logic [3:0]        push;
  logic [3:0]        blocked;
  logic [ADDR_W-1:0] nxt_ptr;
  logic [ADDR_W-1:0] free;
  logic              bp_n;

  assign nxt_ptr  = wr_ptr + 1'b1;
  assign free     = buf_rd_ptr - commit_ptr - 1'b1;
  assign bp_n     = ({1'b0, free} < FRM_LIM) | (|desc_full);
  assign blocked  = portmap & desc_full;
  assign desc_din = {start_addr, body_len};

  function automatic logic [15:0] sat16(
    input logic [15:0] c,
    input logic [2:0]  inc
  );
    logic [16:0] s;
    s = {1'b0, c} + {14'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    state_n   = state;
    wr_ptr_n  = wr_ptr;
    commit_n  = commit_ptr;
    start_n   = start_addr;
    len_n     = body_len;
    pm_n      = portmap;
    we_n      = 1'b0;
    drop_inc  = 3'd0;
    frame_inc = 1'b0;
    push      = 4'd0;
    unique case (state)
      IDLE: begin
        if (sof && dv) begin
          pm_n    = data[3:0];
          state_n = HDR1;
        end
      end
      HDR1: begin
        if (dv) begin
          start_n = wr_ptr;
          len_n   = '0;
          state_n = BODY;
        end else begin
          drop_inc = 3'd1;
          state_n  = IDLE;
        end
      end
      BODY: begin
        if (!dv) begin
          state_n = COMMIT;
        end else if (sof) begin
          // new frame aborts the current one; byte is its byte0
          wr_ptr_n = commit_ptr;
          drop_inc = 3'd1;
          pm_n     = data[3:0];
          state_n  = HDR1;
        end else if (nxt_ptr == buf_rd_ptr ||
                     body_len == BODY_LIM) begin
          wr_ptr_n = commit_ptr;
          drop_inc = 3'd1;
          state_n  = DISCARD;
        end else begin
          we_n     = 1'b1;
          wr_ptr_n = nxt_ptr;
          len_n    = body_len + 1'b1;
        end
      end
      DISCARD: begin
        if (!dv) state_n = IDLE;
      end
      COMMIT: begin
        push     = portmap & ~desc_full;
        // a frame with no destination counts as one drop
        drop_inc = 3'(blocked[0]) + 3'(blocked[1])
                 + 3'(blocked[2]) + 3'(blocked[3])
                 + 3'(portmap == 4'd0);
        if (push == 4'd0) begin
          wr_ptr_n = commit_ptr;
        end else begin
          commit_n  = wr_ptr;
          frame_inc = 1'b1;
        end
        if (sof && dv) begin
          pm_n    = data[3:0];
          state_n = HDR1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign desc_wr = push;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      start_addr <= '0;
      body_len   <= '0;
      portmap    <= '0;
      bp         <= 1'b0;
      dbuf_we    <= 1'b0;
      dbuf_addr  <= '0;
      dbuf_din   <= '0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_n;
      start_addr <= start_n;
      body_len   <= len_n;
      portmap    <= pm_n;
      bp         <= bp_n;
      dbuf_we    <= we_n;
      if (we_n) begin
        dbuf_addr <= wr_ptr;
        dbuf_din  <= data;
      end
      frame_cnt  <= sat16(frame_cnt, {2'd0, frame_inc});
      drop_cnt   <= sat16(drop_cnt, drop_inc);
    end
  end

endmodule

// File: tb/tb_tteframe_ingress_sink.sv
// Randomized bench for tteframe_ingress_sink.
// Frame-level reference model predicts writes, descriptors, counters.
module tb_tteframe_ingress_sink;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sof = 1'b0;
  logic        dv = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        bp;
  logic        dbuf_we;
  logic [11:0] dbuf_addr;
  logic [7:0]  dbuf_din;
  logic [11:0] buf_rd_ptr = 12'd0;
  logic [11:0] commit_ptr;
  logic [3:0]  desc_wr;
  logic [22:0] desc_din;
  logic [3:0]  desc_full = 4'd0;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  tteframe_ingress_sink dut (
    .clk(clk), .rstn(rstn), .sof(sof), .dv(dv), .data(data),
    .bp(bp), .dbuf_we(dbuf_we), .dbuf_addr(dbuf_addr),
    .dbuf_din(dbuf_din), .buf_rd_ptr(buf_rd_ptr),
    .commit_ptr(commit_ptr), .desc_wr(desc_wr),
    .desc_din(desc_din), .desc_full(desc_full),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [11:0] wa_q[$];
  logic [7:0]  wd_q[$];
  logic [3:0]  dw_q[$];
  logic [22:0] dd_q[$];
  logic [11:0] ea_q[$];
  logic [7:0]  ed_q[$];
  logic [3:0]  edw_q[$];
  logic [22:0] edd_q[$];

  always @(negedge clk) begin
    if (rstn) begin
      if (dbuf_we) begin
        wa_q.push_back(dbuf_addr);
        wd_q.push_back(dbuf_din);
      end
      if (desc_wr != 4'd0) begin
        dw_q.push_back(desc_wr);
        dd_q.push_back(desc_din);
      end
    end
  end

  int m_commit = 0;
  int m_frames = 0;
  int m_drops = 0;
  logic [7:0] body[4096];

  task automatic fill(input bit ramp);
    for (int k = 0; k < 4096; k++)
      body[k] = ramp ? 8'(k) : 8'($urandom);
  endtask

  task automatic drive(input logic s, input logic v,
                       input logic [7:0] d);
    @(posedge clk);
    #1;
    sof = s;
    dv = v;
    data = d;
  endtask

  // kind: 0 normal, 1 runt (byte0 only), 2 no tail (next sof aborts)
  task automatic send(input logic [3:0] pm, input int n,
                      input int kind);
    logic [11:0] hl;
    hl = 12'(n + 2);
    drive(1'b1, 1'b1, {hl[11:8], pm});
    if (kind != 1) begin
      drive(1'b0, 1'b1, hl[7:0]);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b1, body[k]);
    end
    if (kind != 2) repeat (4) drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic model(input logic [3:0] pm, input int n,
                       input int kind);
    int cap, lim, w;
    logic [3:0] ok;
    if (kind == 1) begin
      m_drops++;
      return;
    end
    cap = (int'(buf_rd_ptr) - m_commit - 1) & 4095;
    lim = (cap < 2047) ? cap : 2047;
    w = (n < lim) ? n : lim;
    for (int k = 0; k < w; k++) begin
      ea_q.push_back(12'((m_commit + k) & 4095));
      ed_q.push_back(body[k]);
    end
    if (n > lim || kind == 2) begin
      m_drops++;
    end else begin
      ok = pm & ~desc_full;
      m_drops += $countones(pm & desc_full) + ((pm == 4'd0) ? 1 : 0);
      if (ok != 4'd0) begin
        edw_q.push_back(ok);
        edd_q.push_back({12'(m_commit), 11'(n)});
        m_commit = (m_commit + n) & 4095;
        m_frames++;
      end
    end
  endtask

  task automatic verify(input string tag);
    int nw, nd, fr;
    logic exp_bp;
    nw = (wa_q.size() < ea_q.size()) ? wa_q.size() : ea_q.size();
    chk({tag, "_nwr"}, wa_q.size(), ea_q.size());
    for (int i = 0; i < nw; i++) begin
      chk({tag, "_waddr"}, wa_q[i], ea_q[i]);
      chk({tag, "_wdata"}, wd_q[i], ed_q[i]);
    end
    nd = (dw_q.size() < edw_q.size()) ? dw_q.size() : edw_q.size();
    chk({tag, "_ndesc"}, dw_q.size(), edw_q.size());
    for (int i = 0; i < nd; i++) begin
      chk({tag, "_dwr"}, dw_q[i], edw_q[i]);
      chk({tag, "_ddin"}, dd_q[i], edd_q[i]);
    end
    wa_q.delete(); wd_q.delete(); dw_q.delete(); dd_q.delete();
    ea_q.delete(); ed_q.delete(); edw_q.delete(); edd_q.delete();
    fr = (int'(buf_rd_ptr) - m_commit - 1) & 4095;
    exp_bp = (fr < 1536) || (desc_full != 4'd0);
    @(negedge clk);
    chk({tag, "_commit"}, commit_ptr, m_commit);
    chk({tag, "_frames"}, frame_cnt, m_frames);
    chk({tag, "_drops"}, drop_cnt, m_drops);
    chk({tag, "_bp"}, bp, exp_bp);
  endtask

  task automatic frame(input logic [3:0] pm, input int n,
                       input int kind, input string tag);
    send(pm, n, kind);
    model(pm, n, kind);
    if (kind != 2) verify(tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_commit", commit_ptr, 0);
    chk("rst_frames", frame_cnt, 0);
    chk("rst_drops", drop_cnt, 0);
    chk("rst_bp", bp, 0);
    chk("rst_we", dbuf_we, 0);
    chk("rst_desc", desc_wr, 0);
    rstn = 1'b1;

    fill(1'b1);
    frame(4'b0001, 62, 0, "t1_uni");
    chk("t1_commit62", commit_ptr, 62);

    fill(1'b0);
    desc_full = 4'b0010;
    frame(4'b1010, 40, 0, "t2_mcast");

    desc_full = 4'd0;
    fill(1'b0);
    frame(4'b0000, 64, 0, "t3_nopm");

    while (m_commit != 4090) begin
      int n;
      n = 4090 - m_commit;
      if (n > 2000) n = 2000;
      buf_rd_ptr = 12'(m_commit);
      fill(1'b0);
      frame(4'b0001, n, 0, "t4_adv");
    end
    buf_rd_ptr = 12'd100;
    fill(1'b0);
    frame(4'b0100, 20, 0, "t4_wrap");
    chk("t4_commit14", commit_ptr, 14);

    buf_rd_ptr = 12'((m_commit + 10) & 4095);
    fill(1'b0);
    frame(4'b0001, 30, 0, "t5_ovf");

    buf_rd_ptr = 12'(m_commit);
    fill(1'b0);
    frame(4'b0010, 2048, 0, "t5_maxdrop");
    fill(1'b0);
    frame(4'b0010, 2047, 0, "t5_maxok");

    frame(4'b0011, 0, 1, "t6_runt");
    buf_rd_ptr = 12'(m_commit);
    fill(1'b0);
    frame(4'b0001, 15, 2, "t6_abort");
    fill(1'b0);
    frame(4'b1000, 25, 0, "t6_after");

    for (int it = 0; it < 24; it++) begin
      logic [3:0] pm;
      int n, kind;
      pm = 4'($urandom);
      desc_full = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2100)
                                      : $urandom_range(1, 200);
      kind = ($urandom_range(0, 9) == 0) ? 1 : 0;
      buf_rd_ptr = ($urandom_range(0, 1) == 0) ? 12'(m_commit)
                                               : 12'($urandom);
      fill(1'b0);
      frame(pm, n, kind, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
